// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, architectural constants and
// the NOP control word loaded by the stage-register bubble muxes.
package riscv_pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] wb_sel;
    } ctrl_word_t;

    // All-zero control: no register write, no memory access, no control transfer.
    localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/stall sequencer: load-use stalls, taken-branch flushes and
// mul/div freeze with timeout, plus a saturating stall-cycle counter.
module hazard_controller
    import riscv_pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             EX_md_valid,
    input  logic             md_done,
    input  logic             perf_clr,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_bubble,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W    = $clog2(MD_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              md_expired;

    assign load_use = ID_EX_MemRead && (ID_EX_rd != REG_X0) &&
                      ((ID_EX_rd == IF_ID_rs1) ||
                       (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    // md_done on the last allowed cycle is a normal completion, not a timeout.
    assign md_expired = (wait_cnt == WAIT_LAST) && !md_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (!EX_branch_taken && EX_md_valid) begin
                        state <= MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    if (md_done || md_expired) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded combinationally; holding rst_n low forces the idle pattern.
    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        EX_MEM_bubble = 1'b0;
        md_start      = 1'b0;
        md_timeout    = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (EX_md_valid) begin
                        md_start      = 1'b1;
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                    end else if (load_use) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_expired) begin
                        md_timeout = 1'b1;
                    end else if (!md_done) begin
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (!PC_write),
        .clr  (perf_clr),
        .count(stall_cycles)
    );

endmodule
